// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and widths for the instruction fetch unit.
//
// Contents:
//   INST_W / PC_W / MEM_AW : instruction, byte-PC and BRAM word-address widths
//   fetch_state_t          : fetch FSM states (RUN, FAULT)
//   word_addr()            : byte PC -> BRAM word address (drops the 2 byte bits)
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 64;
  localparam int MEM_AW = 14;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  // BRAM word address of a byte PC; wraps naturally modulo 2^MEM_AW words.
  function automatic logic [MEM_AW-1:0] word_addr(input logic [PC_W-1:0] pc);
    return pc[MEM_AW+1:2];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo -- small synchronous FIFO holding {inst, pc} entries for the
// fetch unit. Supports push and pop in the same cycle, including when full.
// A flush empties the FIFO and overrides any same-cycle push or pop.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : drop every entry
//   i_push         : write i_push_data at the tail
//   i_push_data    : {inst, pc} payload
//   i_pop          : retire the head entry
//   o_head         : head entry (meaningful only while o_count != 0)
//   o_count        : number of stored entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int ENTRY_W = INST_W + PC_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_push_data,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_head,
  output logic [CNT_W-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               do_push;
  logic               do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = i_pop && (o_count != '0);
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = i_push && ((o_count != CNT_W'(DEPTH)) || do_pop);
  assign o_head  = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      o_count <= '0;
    end else if (i_flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while counted.
  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) begin
      mem[wr_ptr] <= i_push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- sequential instruction fetch from a 1-cycle-latency BRAM into a
// small instruction buffer presented to the decoder.
//
// Optional feature: define FETCH_MISALIGN_FAULT_EN to trap redirects whose
// target is not 4-byte aligned (enter FAULT, assert o_fault, stop fetching
// until an aligned redirect). Without it o_fault is 0 and target bits [1:0]
// are ignored.
//
// Handshake: the decoder side is valid/ready. o_inst_valid never depends on
// i_inst_ready; an entry is consumed exactly in a cycle where
// o_inst_valid && i_inst_ready, and o_inst/o_inst_pc hold while valid && !ready.
// i_redirect overrides everything in its cycle (the pop is ignored).
//
// Ports:
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   o_mem_read            : BRAM read strobe
//   o_mem_address         : BRAM word address (fetch_pc[15:2])
//   i_mem_value           : BRAM data, valid the cycle after o_mem_read
//   o_inst_valid/o_inst/o_inst_pc : head instruction to the decoder
//   i_inst_ready          : decoder accepts the head
//   i_redirect/i_redirect_pc : flush and restart fetch at a new byte address
//   o_fault               : misaligned-redirect fault (feature builds only)
//   o_dbg_state           : current fetch FSM state (RUN=0, FAULT=1)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic          o_mem_read,
  output logic [13:0]   o_mem_address,
  input  logic [31:0]   i_mem_value,
  output logic          o_inst_valid,
  output logic [31:0]   o_inst,
  output logic [63:0]   o_inst_pc,
  input  logic          i_inst_ready,
  input  logic          i_redirect,
  input  logic [63:0]   i_redirect_pc,
  output logic          o_fault,
  output logic          o_dbg_state
);

  localparam int ENTRY_W = INST_W + PC_W;
  localparam int CNT_W   = $clog2(BUF_DEPTH + 1);

  fetch_state_t       state;
  fetch_state_t       state_nxt;
  logic [PC_W-1:0]    fetch_pc;
  logic [PC_W-1:0]    fetch_pc_nxt;
  logic               inflight;
  logic [PC_W-1:0]    inflight_pc;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;
  logic [PC_W-1:0]    redirect_target;
  logic               redirect_misaligned;
  logic               pop;
  logic               push;
  logic               issue;
  logic [CNT_W:0]     occupancy;
  logic [CNT_W:0]     limit;

`ifdef FETCH_MISALIGN_FAULT_EN
  assign redirect_target     = i_redirect_pc;
  assign redirect_misaligned = (i_redirect_pc[1:0] != 2'b00);
`else
  logic unused_redirect_lowbits;
  assign unused_redirect_lowbits = ^i_redirect_pc[1:0];
  assign redirect_target     = {i_redirect_pc[PC_W-1:2], 2'b00};
  assign redirect_misaligned = 1'b0;
`endif

  // Decoder side.
  assign o_inst_valid = (count != '0);
  assign o_inst       = o_inst_valid ? head[ENTRY_W-1 -: INST_W] : '0;
  assign o_inst_pc    = o_inst_valid ? head[PC_W-1:0] : '0;
  assign pop          = o_inst_valid && i_inst_ready && !i_redirect;

  // Issue while buffered + in-flight entries, after this cycle's pop, leave room.
  // Counting the in-flight read guarantees its push can never overflow.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign limit     = (CNT_W + 1)'(BUF_DEPTH) + {{CNT_W{1'b0}}, pop};
  // Gating with i_rst_n keeps the strobe low while reset is held.
  assign issue     = i_rst_n && (state == RUN) && !i_redirect && (occupancy < limit);

  // A redirect kills the response of the read issued last cycle.
  assign push = inflight && !i_redirect;

  assign o_mem_read    = issue;
  assign o_mem_address = word_addr(fetch_pc);
  assign o_dbg_state   = state;

`ifdef FETCH_MISALIGN_FAULT_EN
  assign o_fault = (state == FAULT);
`else
  assign o_fault = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    if (i_redirect) begin
      fetch_pc_nxt = redirect_target;
      state_nxt    = redirect_misaligned ? FAULT : RUN;
    end else if (issue) begin
      fetch_pc_nxt = fetch_pc + 64'd4;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_redirect),
    .i_push      (push),
    .i_push_data ({i_mem_value, inflight_pc}),
    .i_pop       (pop),
    .o_head      (head),
    .o_count     (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit. Directed scenarios plus a
// randomized phase, all checked against a queue-based reference model of the
// fetch stream (issued PCs in order, flushed on redirect/reset).
module tb_fetch_unit;

  localparam logic [63:0] RESET_PC  = 64'h0;
  localparam int          BUF_DEPTH = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_mem_read;
  logic [13:0] o_mem_address;
  logic [31:0] i_mem_value;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [63:0] o_inst_pc;
  logic        i_inst_ready;
  logic        i_redirect;
  logic [63:0] i_redirect_pc;
  logic        o_fault;
  logic        o_dbg_state;

  always #5 i_clk = ~i_clk;

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .o_mem_read    (o_mem_read),
    .o_mem_address (o_mem_address),
    .i_mem_value   (i_mem_value),
    .o_inst_valid  (o_inst_valid),
    .o_inst        (o_inst),
    .o_inst_pc     (o_inst_pc),
    .i_inst_ready  (i_inst_ready),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_fault       (o_fault),
    .o_dbg_state   (o_dbg_state)
  );

  // BRAM model: word k holds value k, data one cycle after the strobe.
  always @(posedge i_clk) begin
    if (o_mem_read) i_mem_value <= 32'(o_mem_address);
    else            i_mem_value <= 32'hDEAD_BEEF;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] exp_q[$];     // PCs issued and not yet consumed or killed, oldest first
  int          cyc_q[$];     // cycle in which each queued PC was issued
  logic [63:0] exp_fetch;    // next PC the DUT must read
  bit          fault_exp;
  int          reads;
  int          cyc;
  bit          prev_hold;
  logic [31:0] prev_inst;
  logic [63:0] prev_pc;
  logic        s_read, s_valid, s_fault;
  logic [13:0] s_addr;
  logic [31:0] s_inst;
  logic [63:0] s_pc;

  function automatic bit is_fault_target(input logic [63:0] t);
`ifdef FETCH_MISALIGN_FAULT_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] fetch_target(input logic [63:0] t);
`ifdef FETCH_MISALIGN_FAULT_EN
    return t;
`else
    return {t[63:2], 2'b00};
`endif
  endfunction

  // One clock cycle: inputs are already driven just after the falling edge.
  task automatic tick();
    bit          popping;
    bit          exp_valid;
    logic [63:0] e;
    #1;
    s_read = o_mem_read; s_addr = o_mem_address; s_valid = o_inst_valid;
    s_inst = o_inst;     s_pc   = o_inst_pc;     s_fault = o_fault;
    if (!i_rst_n) begin
      exp_q.delete(); cyc_q.delete();
      exp_fetch = RESET_PC; fault_exp = 0; prev_hold = 0;
    end else begin
      check("fault", o_fault, 64'(fault_exp));
      check("occupancy_bound", 64'(exp_q.size() <= BUF_DEPTH), 64'd1);
      exp_valid = (exp_q.size() != 0) && (cyc_q[0] <= cyc - 2);
      check("inst_valid", o_inst_valid, 64'(exp_valid));
      if (prev_hold) begin
        check("hold_inst", o_inst, 64'(prev_inst));
        check("hold_pc", o_inst_pc, prev_pc);
      end
      popping = o_inst_valid && i_inst_ready && !i_redirect;
      check("read_strobe", o_mem_read,
            64'(!fault_exp && !i_redirect && (exp_q.size() - int'(popping) < BUF_DEPTH)));
      if (popping && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        void'(cyc_q.pop_front());
        check("pop_pc", o_inst_pc, e);
        check("pop_inst", o_inst, 64'(e[15:2]));
      end
      if (o_mem_read) begin
        check("read_addr", o_mem_address, 64'(exp_fetch[15:2]));
        exp_q.push_back(exp_fetch);
        cyc_q.push_back(cyc);
        exp_fetch = exp_fetch + 64'd4;
        reads++;
      end
      prev_hold = o_inst_valid && !i_inst_ready && !i_redirect;
      prev_inst = o_inst;
      prev_pc   = o_inst_pc;
      if (i_redirect) begin
        exp_q.delete(); cyc_q.delete();
        exp_fetch = fetch_target(i_redirect_pc);
        fault_exp = is_fault_target(i_redirect_pc);
      end
    end
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_read"}, o_mem_read, 64'd0);
    check({tag, "_mem_address"}, o_mem_address, 64'(RESET_PC[15:2]));
    check({tag, "_inst_valid"}, o_inst_valid, 64'd0);
    check({tag, "_inst"}, o_inst, 64'd0);
    check({tag, "_inst_pc"}, o_inst_pc, 64'd0);
    check({tag, "_fault"}, o_fault, 64'd0);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic redirect_to(input logic [63:0] t);
    i_redirect = 1'b1; i_redirect_pc = t;
    tick();
    check("redirect_no_read", s_read, 64'd0);
    i_redirect = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_rst_n = 1'b0; i_inst_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    cyc = 0; reads = 0; prev_hold = 0; exp_fetch = RESET_PC; fault_exp = 0;
    @(negedge i_clk);
    @(negedge i_clk);
    #1 check_reset_outputs("reset");
    @(negedge i_clk);

    // Reset release: read in cycle 0, inst 0 valid in cycle 2, one per cycle.
    i_rst_n = 1'b1; i_inst_ready = 1'b1;
    tick(); check("c0_read", s_read, 64'd1);
    tick(); check("c1_valid", s_valid, 64'd0);
    tick(); check("c2_valid", s_valid, 64'd1); check("c2_inst", s_inst, 64'd0); check("c2_pc", s_pc, 64'd0);
    tick(); check("c3_inst", s_inst, 64'd1); check("c3_pc", s_pc, 64'd4);
    for (int i = 0; i < 6; i++) begin
      tick(); check("stream_valid", s_valid, 64'd1);
    end

    // Decoder stall from reset: exactly BUF_DEPTH reads, head holds word 0.
    i_inst_ready = 1'b0;
    do_reset();
    reads = 0;
    for (int i = 0; i < 10; i++) tick();
    check("stall_reads", 64'(reads), 64'(BUF_DEPTH));
    check("stall_inst", s_inst, 64'd0);
    i_inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check("drain_order", s_inst, 64'(i));
    end

    // Redirect with a read in flight: stale response must not appear.
    redirect_to(64'h100);
    tick(); check("rd_valid_off", s_valid, 64'd0); check("rd_read", s_read, 64'd1);
    check("rd_addr", s_addr, 64'h40);
    tick();
    tick(); check("rd_first_pc", s_pc, 64'h100); check("rd_first_valid", s_valid, 64'd1);

    // Word-address wrap.
    redirect_to(64'hFFFC);
    tick(); check("wrap_addr0", s_addr, 64'h3FFF);
    tick(); check("wrap_addr1", s_addr, 64'h0);
    tick(); check("wrap_pc0", s_pc, 64'hFFFC);
    tick(); check("wrap_pc1", s_pc, 64'h10000);

    // Misaligned redirect.
    redirect_to(64'h102);
`ifdef FETCH_MISALIGN_FAULT_EN
    for (int i = 0; i < 8; i++) begin
      tick(); check("fault_on", s_fault, 64'd1); check("fault_no_read", s_read, 64'd0);
    end
    redirect_to(64'h200);
    tick(); check("fault_off", s_fault, 64'd0); check("resume_addr", s_addr, 64'h80);
    check("resume_read", s_read, 64'd1);
`else
    tick(); check("nofault", s_fault, 64'd0); check("lowbits_addr", s_addr, 64'h40);
    tick();
    tick(); check("lowbits_pc", s_pc, 64'h100);
`endif

    // 64-bit PC wrap.
    redirect_to(64'hFFFF_FFFF_FFFF_FFF8);
    for (int i = 0; i < 8; i++) tick();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      i_inst_ready = ($urandom_range(0, 99) < 70);
      i_redirect   = ($urandom_range(0, 99) < 4);
      i_redirect_pc = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) i_redirect_pc[1:0] = 2'b00;
      tick();
    end
    i_redirect = 1'b0;
    redirect_to(64'h40);

    // Asynchronous reset mid-stream.
    i_inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #2 i_rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge i_clk);
    tick();
    i_rst_n = 1'b1;
    tick(); check("restart_read", s_read, 64'd1); check("restart_addr", s_addr, 64'(RESET_PC[15:2]));
    tick(); check("restart_no_stale", s_valid, 64'd0);
    for (int i = 0; i < 6; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
